// File: rtl/resource_sched_pkg.sv
// Shared types for the resource scheduler: FSM state, in-flight tag entry and
// the index-width helper used to size requester indices.
package resource_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Widest requester index supported (NUM_REQ up to 8).
    localparam int IDX_MAX_W = 3;

    typedef struct packed {
        logic                 valid;
        logic [IDX_MAX_W-1:0] idx;
    } tag_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/resource_scheduler_rr_pick.sv
// Combinational round-robin picker: scans requesters starting at ptr_i,
// skipping any masked by excl_i, and returns the first hit as a one-hot
// vector plus its index.
module rr_pick
    import resource_sched_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IW      = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    input  logic [NUM_REQ-1:0] excl_i,
    output logic [NUM_REQ-1:0] win_o,
    output logic [IW-1:0]      idx_o,
    output logic               any_o
);

    // First eligible requester at or after the pointer, wrapping around.
    always_comb begin
        int c;
        win_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        c     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            c = int'(ptr_i) + i;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            if (!any_o && req_i[c] && !excl_i[c]) begin
                any_o    = 1'b1;
                win_o[c] = 1'b1;
                idx_o    = IW'(c);
            end
        end
    end

endmodule

// File: rtl/resource_scheduler.sv
// Round-robin scheduler sharing one multi-cycle resource between NUM_REQ
// requesters, with hold-time preemption and a tag pipeline that routes each
// result back to its issuer. Optional starvation checker is compiled in with
// RESOURCE_SCHED_STARVE_CHK_EN.
module resource_scheduler
    import resource_sched_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int MAX_HOLD = 4,
    parameter int LATENCY  = 2,
    parameter int MAX_WAIT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] stall,
    output logic               issue,
    output logic [NUM_REQ-1:0] rsp_valid,
    output logic               busy,
    output logic               starve_err
);

    localparam int                IW       = idx_w(NUM_REQ);
    localparam int                HOLD_W   = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [IW-1:0]     LAST_IDX = IW'(NUM_REQ - 1);

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IW-1:0]       owner_q, owner_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [HOLD_W-1:0]   hold_inc;
    logic                own_req, others, preempt;
    logic [NUM_REQ-1:0]  excl;
    logic [NUM_REQ-1:0]  pick_win;
    logic [IW-1:0]       pick_idx;
    logic                pick_any;
    tag_t                tag_in;
    tag_t                tag_q [LATENCY];

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i  (req),
        .ptr_i  (ptr_q),
        .excl_i (excl),
        .win_o  (pick_win),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    assign grant = grant_q;
    assign stall = req & ~grant_q;
    assign issue = |(grant_q & req);

    // Hold-limit bookkeeping and preemption decision for the current owner.
    always_comb begin
        own_req  = (state_q == GRANT) && req[owner_q];
        others   = |(req & ~grant_q);
        hold_inc = hold_q;
        if (own_req && (hold_q != HOLD_MAX)) hold_inc = hold_q + HOLD_W'(1);
        // The owner's MAX_HOLD-th issue cycle is its last when someone waits.
        preempt  = own_req && (hold_inc == HOLD_MAX) && others;
        excl     = preempt ? grant_q : '0;
    end

    // Next-state logic: arbitrate from IDLE, or on drop/preemption in GRANT.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    grant_d = pick_win;
                    owner_d = pick_idx;
                    ptr_d   = (pick_idx == LAST_IDX) ? '0 : pick_idx + IW'(1);
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (!own_req || preempt) begin
                    if (pick_any) begin
                        grant_d = pick_win;
                        owner_d = pick_idx;
                        ptr_d   = (pick_idx == LAST_IDX) ? '0 : pick_idx + IW'(1);
                        hold_d  = '0;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        hold_d  = '0;
                    end
                end else begin
                    hold_d = hold_inc;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                hold_d  = '0;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        tag_in.valid = issue;
        tag_in.idx   = IDX_MAX_W'(owner_q);
    end

    // Tag shift register mirrors the resource latency; reset drops in-flight tags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= tag_in;
            for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    // Decode the oldest tag into the result-return strobe and derive busy.
    always_comb begin
        rsp_valid = '0;
        if (tag_q[LATENCY-1].valid) rsp_valid[tag_q[LATENCY-1].idx[IW-1:0]] = 1'b1;
        busy = |grant_q;
        for (int i = 0; i < LATENCY; i++) begin
            if (tag_q[i].valid) busy = 1'b1;
        end
    end

`ifdef RESOURCE_SCHED_STARVE_CHK_EN
    localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_q [NUM_REQ];
    logic              starve_q;
    logic              wait_hit;

    // Any requester whose wait count has reached the threshold.
    always_comb begin
        wait_hit = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (wait_q[i] == WAIT_MAX) wait_hit = 1'b1;
        end
    end

    // Per-requester stall counters and the sticky starvation flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REQ; i++) wait_q[i] <= '0;
            starve_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_q[i])
                    wait_q[i] <= '0;
                else if (stall[i] && (wait_q[i] != WAIT_MAX))
                    wait_q[i] <= wait_q[i] + WAIT_W'(1);
            end
            starve_q <= starve_q | wait_hit;
        end
    end

    assign starve_err = starve_q;
`else
    logic unused_max_wait;
    assign unused_max_wait = (MAX_WAIT != 0);
    assign starve_err      = 1'b0;
`endif

endmodule

// File: tb/tb_resource_scheduler.sv
// Directed, table-driven bench for resource_scheduler (NUM_REQ=2, MAX_HOLD=4,
// LATENCY=2, MAX_WAIT=3). Cycle 0 is the first cycle after reset release.
module tb_resource_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [1:0] grant, stall, rsp_valid;
    logic       issue, busy, starve_err;

    int n_checks = 0;
    int n_fail   = 0;

    resource_scheduler #(
        .NUM_REQ  (2),
        .MAX_HOLD (4),
        .LATENCY  (2),
        .MAX_WAIT (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .grant      (grant),
        .stall      (stall),
        .issue      (issue),
        .rsp_valid  (rsp_valid),
        .busy       (busy),
        .starve_err (starve_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         seg;
        logic [1:0] req;
        logic [1:0] grant;
        logic [1:0] stall;
        logic       issue;
        logic [1:0] rsp;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit s, input logic [1:0] r, input logic [1:0] g,
                       input logic [1:0] st, input logic i, input logic [1:0] rv,
                       input logic b);
        vec_t v;
        v.seg = s; v.req = r; v.grant = g; v.stall = st;
        v.issue = i; v.rsp = rv; v.busy = b;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int c, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %0h expected %0h", nm, c, act, exp);
        end
    endtask

    // Assert reset, check the reset-state outputs, release; returns at start of cycle 0.
    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        req   = 2'b11;
        #1;
        chk("rst_grant", -1, 32'(grant), 32'h0);
        chk("rst_stall", -1, 32'(stall), 32'h3);
        chk("rst_issue", -1, 32'(issue), 32'h0);
        chk("rst_rsp",   -1, 32'(rsp_valid), 32'h0);
        chk("rst_busy",  -1, 32'(busy), 32'h0);
        chk("rst_starve", -1, 32'(starve_err), 32'h0);
        @(posedge clk);
        @(negedge clk);
        req   = 2'b00;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit stv_en;
        reset = 1'b0;
        req   = 2'b00;

        // A: sole requester, hold saturates, then drops
        add(1, 2'b01, 2'b00, 2'b01, 0, 2'b00, 0);
        add(0, 2'b01, 2'b01, 2'b00, 1, 2'b00, 1);
        add(0, 2'b01, 2'b01, 2'b00, 1, 2'b00, 1);
        add(0, 2'b01, 2'b01, 2'b00, 1, 2'b01, 1);
        add(0, 2'b01, 2'b01, 2'b00, 1, 2'b01, 1);
        add(0, 2'b01, 2'b01, 2'b00, 1, 2'b01, 1);
        add(0, 2'b00, 2'b01, 2'b00, 0, 2'b01, 1);
        add(0, 2'b00, 2'b00, 2'b00, 0, 2'b01, 1);
        add(0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0);
        // B: both requesting, preemption every MAX_HOLD cycles
        add(1, 2'b11, 2'b00, 2'b11, 0, 2'b00, 0);
        add(0, 2'b11, 2'b01, 2'b10, 1, 2'b00, 1);
        add(0, 2'b11, 2'b01, 2'b10, 1, 2'b00, 1);
        add(0, 2'b11, 2'b01, 2'b10, 1, 2'b01, 1);
        add(0, 2'b11, 2'b01, 2'b10, 1, 2'b01, 1);
        add(0, 2'b11, 2'b10, 2'b01, 1, 2'b01, 1);
        add(0, 2'b11, 2'b10, 2'b01, 1, 2'b01, 1);
        add(0, 2'b11, 2'b10, 2'b01, 1, 2'b10, 1);
        add(0, 2'b11, 2'b10, 2'b01, 1, 2'b10, 1);
        add(0, 2'b11, 2'b01, 2'b10, 1, 2'b10, 1);
        add(0, 2'b11, 2'b01, 2'b10, 1, 2'b10, 1);
        add(0, 2'b11, 2'b01, 2'b10, 1, 2'b01, 1);
        add(0, 2'b11, 2'b01, 2'b10, 1, 2'b01, 1);
        add(0, 2'b11, 2'b10, 2'b01, 1, 2'b01, 1);
        // C: owner drops with the other waiting, back-to-back handover
        add(1, 2'b01, 2'b00, 2'b01, 0, 2'b00, 0);
        add(0, 2'b01, 2'b01, 2'b00, 1, 2'b00, 1);
        add(0, 2'b11, 2'b01, 2'b10, 1, 2'b00, 1);
        add(0, 2'b10, 2'b01, 2'b10, 0, 2'b01, 1);
        add(0, 2'b10, 2'b10, 2'b00, 1, 2'b01, 1);
        add(0, 2'b00, 2'b10, 2'b00, 0, 2'b00, 1);
        add(0, 2'b00, 2'b00, 2'b00, 0, 2'b10, 1);
        add(0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0);
        // D: response routing, issue by 0 in cycle 1 and by 1 in cycle 5
        add(1, 2'b01, 2'b00, 2'b01, 0, 2'b00, 0);
        add(0, 2'b01, 2'b01, 2'b00, 1, 2'b00, 1);
        add(0, 2'b00, 2'b01, 2'b00, 0, 2'b00, 1);
        add(0, 2'b00, 2'b00, 2'b00, 0, 2'b01, 1);
        add(0, 2'b10, 2'b00, 2'b10, 0, 2'b00, 0);
        add(0, 2'b10, 2'b10, 2'b00, 1, 2'b00, 1);
        add(0, 2'b00, 2'b10, 2'b00, 0, 2'b00, 1);
        add(0, 2'b00, 2'b00, 2'b00, 0, 2'b10, 1);
        add(0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0);
        // E: saturated sole owner is preempted as soon as another arrives
        add(1, 2'b01, 2'b00, 2'b01, 0, 2'b00, 0);
        add(0, 2'b01, 2'b01, 2'b00, 1, 2'b00, 1);
        add(0, 2'b01, 2'b01, 2'b00, 1, 2'b00, 1);
        add(0, 2'b01, 2'b01, 2'b00, 1, 2'b01, 1);
        add(0, 2'b01, 2'b01, 2'b00, 1, 2'b01, 1);
        add(0, 2'b01, 2'b01, 2'b00, 1, 2'b01, 1);
        add(0, 2'b01, 2'b01, 2'b00, 1, 2'b01, 1);
        add(0, 2'b11, 2'b01, 2'b10, 1, 2'b01, 1);
        add(0, 2'b11, 2'b10, 2'b01, 1, 2'b01, 1);

        begin
            int cyc;
            cyc = 0;
            foreach (vecs[k]) begin
                if (vecs[k].seg) begin
                    do_reset();
                    cyc = 0;
                end
                req = vecs[k].req;
                @(negedge clk);
                chk("grant", cyc, 32'(grant),     32'(vecs[k].grant));
                chk("stall", cyc, 32'(stall),     32'(vecs[k].stall));
                chk("issue", cyc, 32'(issue),     32'(vecs[k].issue));
                chk("rsp",   cyc, 32'(rsp_valid), 32'(vecs[k].rsp));
                chk("busy",  cyc, 32'(busy),      32'(vecs[k].busy));
                @(posedge clk);
                #1;
                cyc++;
            end
        end

        // Reset asserted with an issue in flight: tags are discarded.
        do_reset();
        req = 2'b01;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_issue", 2, 32'(issue), 32'h1);
        reset = 1'b0;
        #1;
        chk("mid_rst_grant", 2, 32'(grant), 32'h0);
        chk("mid_rst_busy",  2, 32'(busy),  32'h0);
        chk("mid_rst_stall", 2, 32'(stall), 32'h1);
        chk("mid_rst_rsp",   2, 32'(rsp_valid), 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_rsp_hold", 3, 32'(rsp_valid), 32'h0);
        req   = 2'b00;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_rst_rsp",  c, 32'(rsp_valid), 32'h0);
            chk("post_rst_busy", c, 32'(busy),      32'h0);
        end

        // Starvation flag: sets in cycle 4 with both requesting, sticky until reset.
`ifdef RESOURCE_SCHED_STARVE_CHK_EN
        stv_en = 1'b1;
`else
        stv_en = 1'b0;
`endif
        do_reset();
        for (int c = 0; c < 11; c++) begin
            req = (c < 8) ? 2'b11 : 2'b00;
            @(negedge clk);
            chk("starve_err", c, 32'(starve_err), 32'(stv_en && (c >= 4)));
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        #1;
        chk("starve_err_rst", 11, 32'(starve_err), 32'h0);
        reset = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/resource_scheduler.md
# resource_scheduler

Round-robin scheduler that shares one multi-cycle shared resource between `NUM_REQ` pipeline requesters. It issues one-hot registered grants, caps how long one requester may hold the resource, and drives per-requester stalls. It tracks in-flight issues so each resource result returns as `rsp_valid` to the requester that issued it. It sits between the pipelines' `arbiter_req`/`arbiter_grant` handshake and the shared resource's input mux and output valid.

## Interface
- `NUM_REQ`, default 2: number of requesters, range 2–8.
- `MAX_HOLD`, default 4: maximum consecutive grant cycles per requester while another requester is waiting, range 1–255.
- `LATENCY`, default 2: shared resource input-to-output latency in cycles, range 1–16.
- `MAX_WAIT`, default 16: starvation threshold in cycles. Used only when `RESOURCE_SCHED_STARVE_CHK_EN` is defined.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  level request per requester.
- `grant`  out  NUM_REQ  registered, one-hot or zero; selects the resource input mux.
- `stall`  out  NUM_REQ  `req & ~grant`, combinational from `req` and registered `grant`.
- `issue`  out  1  `|(grant & req)`; a valid operation entered the resource this cycle.
- `rsp_valid`  out  NUM_REQ  one-hot result-return strobe.
- `busy`  out  1  grant active or any issue still in flight.
- `starve_err`  out  1  sticky starvation flag. Tied to 0 when the feature is compiled out.

## Operation
- States are IDLE and GRANT. Encoding and the `ptr`/`hold_cnt` registers are internal.
- IDLE:
  - `grant` = 0.
  - If `|req`, pick a winner round-robin starting at `ptr`, the index after the last granted requester. Go to GRANT with that one-hot grant.
- GRANT, owner `k`: `hold_cnt` increments each cycle that `req[k] & grant[k]`. It saturates at `MAX_HOLD`. Rearbitration happens when either:
  - `req[k]` = 0, or
  - `hold_cnt` = `MAX_HOLD` and some other `req` is high.
- Outcome of rearbitration:
  - Pick the next requester round-robin, excluding `k` if it was preempted. The new grant follows back-to-back, with no idle cycle.
  - If no request is pending, go to IDLE.
  - If `k` is the sole requester, it keeps the grant indefinitely and `hold_cnt` stays saturated.
  - Each switch sets `ptr` = (new owner + 1) mod `NUM_REQ` and clears `hold_cnt`.
- Tag pipeline: a `LATENCY`-deep shift register of {valid, index} entries.
  - It is pushed every cycle with {`issue`, owner index}.
  - `rsp_valid[i]` = 1 exactly `LATENCY` cycles after a cycle in which `grant[i] & req[i]`.
- `busy` = `|grant` OR any valid tag entry.
- Reset mid-operation: all state clears immediately and in-flight tags are discarded, so no `rsp_valid` fires after reset. Reset values:
  - state IDLE
  - `grant` = 0
  - `ptr` = 0
  - `hold_cnt` = 0
  - tags invalid
  - `rsp_valid` = 0
  - `starve_err` = 0
  - `busy` = 0
  - `stall` = `req`
  - `issue` = 0

## Timing
- Grant latency:
  - `req` rises in cycle t with the scheduler in IDLE → `grant` is high in t+1.
  - `stall` is high in t and low in t+1.
- A requester that drops `req` in cycle t loses its grant in t+1, and the next winner is granted in t+1.
- Preemption:
  - The owner issues in its grant cycles 1 through `MAX_HOLD`, then `grant` moves in the next cycle.
  - Example: owner granted in cycles 1–4 with `MAX_HOLD` = 4 → new owner in cycle 5.
- Simultaneous requests from IDLE after reset: requester 0 wins.
- `rsp_valid` is registered, with fixed latency `LATENCY` from `issue`. At most one bit is high per cycle.

## Configuration
- `RESOURCE_SCHED_STARVE_CHK_EN` defined:
  - Per-requester wait counters increment while `stall[i]` is high and clear when `grant[i]` is high.
  - When a counter reaches `MAX_WAIT`, `starve_err` sets and holds until reset.
- Not defined: no counters are instantiated and `starve_err` = 0.

## Structure
- Package `resource_sched_pkg`:
  - state enum (IDLE, GRANT)
  - tag entry struct {valid, index}
  - width function for `$clog2(NUM_REQ)`
- Sub-module `rr_pick`: combinational round-robin picker with inputs `req`, `ptr`, and an exclude mask. Its output is a one-hot winner plus an index.

## Test plan
- Single requester, `req` = 01 from cycle 0:
  - `grant` = 01 in cycle 1 and stays.
  - `rsp_valid` = 01 every cycle from cycle 3 onward (`LATENCY` = 2).
  - `stall` = 00 from cycle 1.
- Both requesters from reset, `req` = 11 held:
  - `grant` = 01 in cycles 1–4, 10 in cycles 5–8, then 01 in cycles 9–12.
  - `stall[1]` high in cycles 1–4.
- Owner drop: requester 0 granted, `req[0]` falls in cycle 3 with `req[1]` high → `grant` = 10 in cycle 4, no gap.
- Response routing: one issue by requester 0 in cycle 1 and by requester 1 in cycle 5 → `rsp_valid` = 01 in cycle 3 and 10 in cycle 7.
- Reset with an issue in flight in cycle 2 (`LATENCY` = 2) → no `rsp_valid` after reset; `grant` = 0 and `busy` = 0 during reset.
- With `RESOURCE_SCHED_STARVE_CHK_EN`, `MAX_WAIT` = 3, `MAX_HOLD` = 4, `req` = 11 → `starve_err` set in cycle 4 and sticky until reset.
